// File: rtl/iiitb_r2_4bit_bm_ctrl_if.sv
// Bundle of the operand, multiplier and result channels of the Booth
// multiplier issue/capture controller. The controller sits on the slave
// modport; the surrounding logic (or a bench) sits on the master modport.
interface iiitb_r2_4bit_bm_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_m;
  logic [WIDTH-1:0]     in_q;
  logic                 bm_load;
  logic [WIDTH-1:0]     bm_m;
  logic [WIDTH-1:0]     bm_q;
  logic [2*WIDTH-1:0]   bm_p;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;
  logic                 busy;
  logic                 mismatch;
  logic [CNT_W-1:0]     op_count;

  modport slave (
    input  in_valid, in_m, in_q, bm_p, out_ready,
    output in_ready, bm_load, bm_m, bm_q, out_valid, out_p, busy, mismatch, op_count
  );

  modport master (
    output in_valid, in_m, in_q, bm_p, out_ready,
    input  in_ready, bm_load, bm_m, bm_q, out_valid, out_p, busy, mismatch, op_count
  );
endinterface

// File: rtl/iiitb_r2_4bit_bm_ctrl.sv
// Issue/capture controller around the radix-2 4-bit Booth multiplier.
// Accepts a signed operand pair, loads the multiplier for one cycle, waits
// the fixed iteration latency, captures P, hands it off downstream and keeps
// a sticky flag if P ever disagrees with a full-width reference product.
module iiitb_r2_4bit_bm_ctrl #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  iiitb_r2_4bit_bm_ctrl_if.slave  bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]              state;
  logic [LAT_W-1:0]        lat_cnt;
  logic signed [WIDTH-1:0] m_reg;
  logic signed [WIDTH-1:0] q_reg;
  logic signed [PW-1:0]    p_reg;
  logic                    out_vld;
  logic                    mism;
  logic [CNT_W-1:0]        cnt;
  logic                    p_bad;

  // Reference product: both operands sign-extended to the product width so
  // the extremes (-8*-8, -8*7) cannot overflow.
  function automatic logic signed [PW-1:0] ref_product(
    input logic signed [WIDTH-1:0] m,
    input logic signed [WIDTH-1:0] q
  );
    logic signed [PW-1:0] m_ext;
    logic signed [PW-1:0] q_ext;
    m_ext = {{WIDTH{m[WIDTH-1]}}, m};
    q_ext = {{WIDTH{q[WIDTH-1]}}, q};
    return m_ext * q_ext;
  endfunction

  assign p_bad = ($signed(bus.bm_p) != ref_product(m_reg, q_reg));

  // Sequencer: state, latency counter, result handshake, error flag, op count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      out_vld <= 1'b0;
      mism    <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) state <= S_LOAD;
        end
        S_LOAD: begin
          lat_cnt <= '0;
          state   <= S_RUN;
        end
        S_RUN: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
          if (lat_cnt == LAT_LAST) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          out_vld <= 1'b1;
          if (p_bad) mism <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_vld <= 1'b0;
            cnt     <= cnt + CNT_W'(1);
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand and product registers: operands held from accept until the next
  // accept, product captured once per operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_reg <= '0;
      q_reg <= '0;
      p_reg <= '0;
    end else begin
      if (state == S_IDLE && bus.in_valid) begin
        m_reg <= bus.in_m;
        q_reg <= bus.in_q;
      end
      if (state == S_CAPTURE) p_reg <= bus.bm_p;
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.bm_load   = (state == S_LOAD);
  assign bus.busy      = (state != S_IDLE);
  assign bus.bm_m      = m_reg;
  assign bus.bm_q      = q_reg;
  assign bus.out_p     = p_reg;
  assign bus.out_valid = out_vld;
  assign bus.mismatch  = mism;
  assign bus.op_count  = cnt;

endmodule

// File: tb/tb_iiitb_r2_4bit_bm_ctrl.sv
// Directed bench for the Booth multiplier issue/capture controller, with a
// small behavioural multiplier that presents junk on P until the product is
// ready four clocks after the load cycle.
module tb_iiitb_r2_4bit_bm_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fault_mode = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] mdl_m, mdl_q;
  int         mdl_cnt;

  logic [3:0] bb_m [3] = '{4'h7, 4'h8, 4'h7};
  logic [3:0] bb_q [3] = '{4'h7, 4'h8, 4'h8};
  logic [7:0] bb_p [3] = '{8'h31, 8'h40, 8'hC8};

  iiitb_r2_4bit_bm_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus ();

  iiitb_r2_4bit_bm_ctrl #(.WIDTH(4), .LATENCY(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mul_model(input logic [3:0] m, input logic [3:0] q);
    logic signed [7:0] a, b;
    a = {{4{m[3]}}, m};
    b = {{4{q[3]}}, q};
    return a * b;
  endfunction

  // Behavioural multiplier: P is junk until four edges after the load edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_cnt  <= 0;
      bus.bm_p <= 8'h00;
    end else if (bus.bm_load) begin
      mdl_m    <= bus.bm_m;
      mdl_q    <= bus.bm_q;
      mdl_cnt  <= 1;
      bus.bm_p <= 8'hA5;
    end else if (mdl_cnt != 0) begin
      if (mdl_cnt == 4) begin
        bus.bm_p <= fault_mode ? 8'h00 : mul_model(mdl_m, mdl_q);
        mdl_cnt  <= 0;
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation: accept, load pulse, latency, optional backpressure, handoff.
  task automatic do_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp_p,
                       input int hold, input logic [7:0] exp_cnt);
    int lat;
    bus.in_m = m;
    bus.in_q = q;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("accept_bm_m", bus.bm_m, m);
    check("accept_bm_q", bus.bm_q, q);
    check("load_high", bus.bm_load, 1'b1);
    check("in_ready_busy", bus.in_ready, 1'b0);
    @(negedge clk);
    check("load_low", bus.bm_load, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 6);
    check("out_p", bus.out_p, exp_p);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_p", bus.out_p, exp_p);
      check("hold_in_ready", bus.in_ready, 1'b0);
      check("hold_count", bus.op_count, exp_cnt - 8'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("handoff_valid", bus.out_valid, 1'b0);
    check("handoff_count", bus.op_count, exp_cnt);
    check("handoff_in_ready", bus.in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.in_m      = 4'h0;
    bus.in_q      = 4'h0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_load", bus.bm_load, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_p", bus.out_p, 8'h00);
    check("rst_bm_m", bus.bm_m, 4'h0);
    check("rst_mismatch", bus.mismatch, 1'b0);
    check("rst_count", bus.op_count, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // -6 * -5 = 30
    do_op(4'b1010, 4'b1011, 8'h1E, 0, 8'd1);
    check("t1_mismatch", bus.mismatch, 1'b0);

    // Back-to-back with in_valid held and out_ready high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_m      = bb_m[0];
    bus.in_q      = bb_q[0];
    for (int i = 0; i < 3; i++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!bus.out_valid && lat < 30);
      check("b2b_latency", lat, 7);
      check("b2b_out_p", bus.out_p, bb_p[i]);
      check("b2b_in_ready", bus.in_ready, 1'b0);
      check("b2b_busy", bus.busy, 1'b1);
      @(negedge clk);
      check("b2b_idle_ready", bus.in_ready, 1'b1);
      if (i < 2) begin
        bus.in_m = bb_m[i+1];
        bus.in_q = bb_q[i+1];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.out_ready = 1'b0;
    check("b2b_count", bus.op_count, 8'd4);
    check("b2b_mismatch", bus.mismatch, 1'b0);

    // Backpressure: 3 * 2 = 6 held for five cycles
    do_op(4'b0011, 4'b0010, 8'h06, 5, 8'd5);

    // Faulty multiplier, then a correct op: mismatch stays set
    fault_mode = 1'b1;
    do_op(4'b0101, 4'b0011, 8'h00, 0, 8'd6);
    check("fault_mismatch", bus.mismatch, 1'b1);
    fault_mode = 1'b0;
    do_op(4'b0001, 4'b0001, 8'h01, 0, 8'd7);
    check("sticky_mismatch", bus.mismatch, 1'b1);

    // Reset in RUN, three edges after accept
    bus.in_m = 4'b0010;
    bus.in_q = 4'b0010;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("run_busy", bus.busy, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_load", bus.bm_load, 1'b0);
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_in_ready", bus.in_ready, 1'b1);
    check("abort_count", bus.op_count, 8'd0);
    check("abort_mismatch", bus.mismatch, 1'b0);
    check("abort_bm_q", bus.bm_q, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(4'b1111, 4'b1111, 8'h01, 0, 8'd1);
    check("post_rst_mismatch", bus.mismatch, 1'b0);

    // 255 more operations: count wraps from 255 to 0
    bus.in_m = 4'b0010;
    bus.in_q = 4'b1101;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 255; n++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!bus.out_valid && lat < 30);
      check("wrap_latency", lat, 7);
      check("wrap_out_p", bus.out_p, 8'hFA);
      if (n == 254) check("wrap_pre", bus.op_count, 8'hFF);
      @(negedge clk);
      if (n == 254) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    check("wrap_count", bus.op_count, 8'h00);
    check("wrap_idle", bus.in_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
